// File: rtl/prog_free_run_counter_if.sv
// Control/status bundle for prog_free_run_counter: the controller drives the
// master side and the counter implements the slave side.
interface prog_free_run_counter_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PRESCALE_W = 16
);
    logic                  enable;
    logic [PRESCALE_W-1:0] prescale;
    logic [1:0]            mode;
    logic [WIDTH-1:0]      limit;
    logic                  load;
    logic [WIDTH-1:0]      load_value;
    logic                  clear_wrap;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  wrap_flag;
    logic                  done;

    modport master (
        output enable, prescale, mode, limit, load, load_value, clear_wrap,
        input  count, tc, wrap_flag, done
    );

    modport slave (
        input  enable, prescale, mode, limit, load, load_value, clear_wrap,
        output count, tc, wrap_flag, done
    );
endinterface

// File: rtl/prog_free_run_counter.sv
// Programmable free-running counter: prescaled up/down stepping with wrap or
// one-shot terminal behaviour, synchronous load, tc pulse and sticky wrap flag.
module prog_free_run_counter #(
    parameter int unsigned     WIDTH       = 32,
    parameter int unsigned     PRESCALE_W  = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    prog_free_run_counter_if.slave bus
);
    typedef enum logic [1:0] {
        UP_WRAP      = 2'b00,
        DOWN_WRAP    = 2'b01,
        UP_ONESHOT   = 2'b10,
        DOWN_ONESHOT = 2'b11
    } mode_e;

    mode_e                 mode;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  tc_q, tc_d;
    logic                  wrap_q, wrap_d;
    logic                  done_q, done_d;
    logic                  step;

    assign mode = mode_e'(bus.mode);
    assign step = bus.enable & ~done_q & (pre_cnt_q == bus.prescale);

    always_comb begin
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        tc_d      = 1'b0;
        done_d    = done_q;
        if (bus.load) begin
            count_d   = bus.load_value;
            pre_cnt_d = '0;
            done_d    = 1'b0;
        end else begin
            if (bus.enable)
                pre_cnt_d = step ? '0 : pre_cnt_q + 1'b1;
            if (step) begin
                unique case (mode)
                    UP_WRAP: begin
                        if (count_q >= bus.limit) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    DOWN_WRAP: begin
                        if (count_q == '0) begin
                            count_d = bus.limit;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                    UP_ONESHOT: begin
                        if (count_q >= bus.limit) begin
                            done_d = 1'b1;
                            tc_d   = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    DOWN_ONESHOT: begin
                        if (count_q == '0) begin
                            done_d = 1'b1;
                            tc_d   = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                endcase
            end
        end
        // A terminal event being produced or currently shown beats a clear.
        wrap_d = (wrap_q & ~bus.clear_wrap) | tc_d | tc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= RESET_VALUE;
            pre_cnt_q <= '0;
            tc_q      <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            pre_cnt_q <= pre_cnt_d;
            tc_q      <= tc_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.tc        = tc_q;
    assign bus.wrap_flag = wrap_q;
    assign bus.done      = done_q;
endmodule
